// File: rtl/ex_operand_fwd_mux.sv
// Registered per-channel operand selector for EX forwarding, buffered by a 2-entry skid stage.
// Optional forward counters are compiled in with FWD_MUX_STATS_EN.
module ex_operand_fwd_mux #(
  parameter int                 DATA_W      = 32,
  parameter int                 NUM_SRC     = 3,
  parameter int                 NUM_CH      = 2,
  parameter logic [DATA_W-1:0]  DEFAULT_VAL = '0,
  localparam int                SEL_W       = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NUM_SRC*DATA_W-1:0] in_src,
  input  logic [NUM_CH*SEL_W-1:0]   in_sel,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_CH*DATA_W-1:0]  out_data,
  output logic [NUM_CH-1:0]         out_sel_err
`ifdef FWD_MUX_STATS_EN
  ,
  input  logic                      stat_clr,
  output logic [NUM_CH*32-1:0]      stat_fwd_cnt
`endif
);

  logic [NUM_CH*DATA_W-1:0] sel_data;
  logic [NUM_CH-1:0]        sel_err;

  logic                     m_valid_q, m_valid_d;
  logic                     s_valid_q, s_valid_d;
  logic                     ready_q;
  logic [NUM_CH*DATA_W-1:0] m_data_q, s_data_q;
  logic [NUM_CH-1:0]        m_err_q, s_err_q;
  logic                     m_load_in, m_load_s, s_load;
  logic                     accept, drain;

  assign accept = in_valid & ready_q;
  assign drain  = m_valid_q & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SEL_W-1:0]  ch_sel;
      logic [DATA_W-1:0] ch_data;
      logic              ch_err;

      assign ch_sel = in_sel[gi*SEL_W +: SEL_W];

      always_comb begin
        ch_data = DEFAULT_VAL;
        ch_err  = 1'b1;
        for (int k = 0; k < NUM_SRC; k++) begin
          if (ch_sel == SEL_W'(k)) begin
            ch_data = in_src[k*DATA_W +: DATA_W];
            ch_err  = 1'b0;
          end
        end
      end

      assign sel_data[gi*DATA_W +: DATA_W] = ch_data;
      assign sel_err[gi]                   = ch_err;

`ifdef FWD_MUX_STATS_EN
      // A forward is an accepted, in-range, non-register-file select; flush does not undo it.
      logic [31:0] cnt_q, cnt_d;
      always_comb begin
        cnt_d = cnt_q;
        if (stat_clr)
          cnt_d = '0;
        else if (accept && !ch_err && (ch_sel != '0) && (cnt_q != 32'hFFFF_FFFF))
          cnt_d = cnt_q + 32'd1;
      end
      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end
      assign stat_fwd_cnt[gi*32 +: 32] = cnt_q;
`else
      // No statistics hardware in this build.
`endif
    end
  endgenerate

  // M empty never coexists with S full, so a refill from S only happens while M drains.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_load_in = 1'b0;
    m_load_s  = 1'b0;
    s_load    = 1'b0;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q || drain) begin
      if (s_valid_q) begin
        m_load_s  = 1'b1;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (accept) begin
        m_load_in = 1'b1;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (accept) begin
      s_load    = 1'b1;
      s_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      ready_q   <= !s_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_data_q <= '0;
      m_err_q  <= '0;
      s_data_q <= '0;
      s_err_q  <= '0;
    end else begin
      if (m_load_in) begin
        m_data_q <= sel_data;
        m_err_q  <= sel_err;
      end else if (m_load_s) begin
        m_data_q <= s_data_q;
        m_err_q  <= s_err_q;
      end
      if (s_load) begin
        s_data_q <= sel_data;
        s_err_q  <= sel_err;
      end
    end
  end

  assign in_ready    = ready_q;
  assign out_valid   = m_valid_q;
  assign out_data    = m_data_q;
  assign out_sel_err = m_err_q;

endmodule

// File: doc/ex_operand_fwd_mux.md
Name: ex_operand_fwd_mux

Overview:
Parametrised, registered operand-forwarding selector for the EX stage. Each cycle, every channel picks one of NUM_SRC shared source buses using its own select code. Typical sources are the register-file value, the EX/MEM result and the MEM/WB result. Results are registered behind a 2-entry skid buffer with a valid/ready handshake, so EX can stall without dropping or duplicating operands. Out-of-range selects are flagged per channel, not silently zeroed.

Parameters:
DATA_W, 32, width of each source bus and each output operand
NUM_SRC, 3, number of selectable sources (>=2)
SEL_W, $clog2(NUM_SRC) (min 1), width of each channel select code (derived, not overridden)
NUM_CH, 2, number of independent output operands (A, B, ...)
DEFAULT_VAL, 32'h00000000, value driven for an out-of-range select

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard all buffered operands (branch/exception squash)
in_valid  in  1  upstream has a valid operand set
in_ready  out  1  block can accept this cycle
in_src  in  NUM_SRC*DATA_W  source buses, source k at bits [k*DATA_W +: DATA_W]
in_sel  in  NUM_CH*SEL_W  select codes, channel c at [c*SEL_W +: SEL_W]
out_valid  out  1  output operand set valid
out_ready  in  1  downstream consumes this cycle
out_data  out  NUM_CH*DATA_W  selected operands, channel c at [c*DATA_W +: DATA_W]
out_sel_err  out  NUM_CH  channel c's select was >= NUM_SRC

Behaviour:
- Clock and reset: one clock `clk`. Reset `reset` is synchronous and active-high.
- Selection (combinational, on the input side):
  - Per channel, sel < NUM_SRC gives the corresponding source; otherwise DEFAULT_VAL with error bit = 1.
  - Selection and error are captured together into the buffer entry.
- Handshake:
  - Transfer in occurs when in_valid & in_ready.
  - Transfer out occurs when out_valid & out_ready.
  - Holding: out_data and out_sel_err stay stable while out_valid=1 and out_ready=0.
- Buffer: main entry M (drives outputs) plus skid entry S.
  - in_ready = !S.valid, driven directly from a register with no combinational path from out_ready.
  - Accept with M empty, or with M draining this cycle: the new data goes to M.
  - Accept with M full and not draining: the new data goes to S.
  - M drains while S is full: S moves to M and S becomes empty.
  - Simultaneous accept and drain with S empty: M is replaced and S stays empty.
  - Ordering is strictly FIFO. Full throughput is one transfer per cycle when out_ready=1.
- Latency: an accepted set appears on out_data the cycle after acceptance when M was empty or draining. Otherwise it appears when it reaches M.
- flush:
  - On the flush edge, M.valid and S.valid clear.
  - A transfer in on the same cycle is dropped (flush wins).
  - A same-cycle drain still counts as consumed downstream.
  - in_ready = 1 on the following cycle.
- Reset: out_valid=0, out_data=0, out_sel_err=0, and both entries are invalid. in_ready=0 while reset is asserted and 1 on the first cycle after deassertion. Reset mid-transfer discards all buffered data.
- Data registers load only on accept/shift, not every cycle, which reduces toggling.

Optional Feature:
Macro FWD_MUX_STATS_EN.
- Defined: adds output port stat_fwd_cnt (NUM_CH*32) and input stat_clr (1).
  - Per channel, a 32-bit counter increments on each transfer in whose select is non-zero and in range (an actual forward).
  - The counter saturates at 32'hFFFFFFFF.
  - reset or stat_clr sets it to 0. stat_clr has priority over a same-cycle increment.
  - Counting is unaffected by flush.
- Undefined: neither port exists, and no counter logic is present.

Test Plan:
1. Defaults, out_ready=1. Send sel A=1, B=2 with src0=0x11, src1=0x22, src2=0x33 -> next cycle out_valid=1, A=0x22, B=0x33, err=2'b00. Back-to-back sets stream at 1 per cycle.
2. out_ready=0, send 2 sets (A=src0 then A=src2) -> in_ready drops to 0 after the second. out_data holds the first set stable for 5 cycles. Raise out_ready -> both emerge in order, and in_ready returns to 1.
3. Channel A sel=2'b11 with NUM_SRC=3 -> A=0x00000000, out_sel_err[0]=1. Channel B is unaffected, err[1]=0.
4. With M and S full, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1. The flushed-cycle input never appears at the output.
5. Assert reset mid-stream with S full -> next cycle out_valid=0, out_data=0, err=0. First cycle after reset, in_ready=1.
6. With FWD_MUX_STATS_EN, 10 transfers where A sel=1 (4 times), A sel=0 (6 times), B sel=3 (all 10, out of range) -> stat A=4, B=0. Pulse stat_clr -> A=0.
